// File: rtl/mult_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier (mult_booth).
package mult_pkg;

    localparam int ITER  = 16;
    localparam int ACC_W = 34;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        PA,
        P2A,
        NA,
        N2A
    } booth_sel_t;

    // bits = {multiplier[1:0], previous multiplier bit}
    function automatic booth_sel_t booth_decode(input logic [2:0] bits);
        booth_sel_t sel;
        case (bits)
            3'b001, 3'b010: sel = PA;
            3'b011:         sel = P2A;
            3'b100:         sel = N2A;
            3'b101, 3'b110: sel = NA;
            default:        sel = ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mult_booth_step.sv
// One Booth accumulation: recode select, optional inversion, 34-bit carry-lookahead add.
module booth_step
    import mult_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] mcand,
    input  logic [2:0]       recode,
    output logic [ACC_W-1:0] sum
);

    booth_sel_t       sel;
    logic [ACC_W-1:0] operand;
    logic             cin;
    logic [ACC_W-1:0] p;
    logic [ACC_W-2:0] g;
    logic [ACC_W-1:0] c;
    logic [7:0]       gg;
    logic [7:0]       gp;
    logic [8:0]       cg;

    assign sel = booth_decode(recode);

    // Negative multiples are two's complement: inverted operand plus carry-in.
    always_comb begin
        operand = '0;
        cin     = 1'b0;
        case (sel)
            PA:      operand = mcand;
            P2A:     operand = {mcand[ACC_W-2:0], 1'b0};
            NA: begin
                operand = ~mcand;
                cin     = 1'b1;
            end
            N2A: begin
                operand = ~{mcand[ACC_W-2:0], 1'b0};
                cin     = 1'b1;
            end
            default: operand = '0;
        endcase
    end

    assign p = acc ^ operand;
    assign g = acc[ACC_W-2:0] & operand[ACC_W-2:0];

    // Eight 4-bit lookahead groups chained on group carries, plus a 2-bit tail.
    always_comb begin
        gg    = '0;
        gp    = '0;
        cg    = '0;
        c     = '0;
        cg[0] = cin;
        for (int k = 0; k < 8; k++) begin
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
            cg[k+1] = gg[k] | (gp[k] & cg[k]);
        end
        for (int k = 0; k < 8; k++) begin
            c[4*k]   = cg[k];
            c[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cg[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
        end
        c[32] = cg[8];
        c[33] = g[32] | (p[32] & cg[8]);
    end

    assign sum = p ^ c;

endmodule

// File: rtl/mult_booth.sv
// Sequential 32x32 signed radix-4 Booth multiplier, 16-step latency.
// MULT_EXCEPTION_EN enables the signed-overflow flag; otherwise data_exception is tied to 0.
module mult_booth
    import mult_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_mult,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output state_t      dbg_state
);

    // Handshake: ctrl_mult is a one-cycle request that is always accepted (no ready);
    // it restarts any operation in flight. data_resultRDY is a one-cycle valid with no
    // ready: data_result/data_exception are valid in that cycle and hold until the next one.

    state_t           state, next_state;
    logic             load, step, finish;
    logic [3:0]       count;
    logic [ACC_W-1:0] acc, mcand, step_sum, next_acc;
    logic [31:0]      mreg, next_mreg;
    logic             q_m1;
    logic             exc_next;

    booth_step u_step (
        .acc    (acc),
        .mcand  (mcand),
        .recode ({mreg[1:0], q_m1}),
        .sum    (step_sum)
    );

    // Arithmetic shift of {acc, mreg, q_m1} right by two.
    assign next_acc  = {{2{step_sum[ACC_W-1]}}, step_sum[ACC_W-1:2]};
    assign next_mreg = {step_sum[1:0], mreg[31:2]};

`ifdef MULT_EXCEPTION_EN
    assign exc_next = (next_acc[31:0] != {32{next_mreg[31]}});
`else
    assign exc_next = 1'b0;
`endif

    assign dbg_state = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_mult) begin
                    next_state = BUSY;
                    load       = 1'b1;
                end
            end
            BUSY: begin
                if (ctrl_mult) begin
                    load = 1'b1;
                end else begin
                    step = 1'b1;
                    if (count == 4'(ITER - 1)) begin
                        next_state = DONE;
                        finish     = 1'b1;
                    end
                end
            end
            DONE: begin
                if (ctrl_mult) begin
                    next_state = BUSY;
                    load       = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc            <= '0;
            mcand          <= '0;
            mreg           <= '0;
            q_m1           <= 1'b0;
            count          <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= finish;
            if (load) begin
                acc   <= '0;
                mreg  <= data_operandB;
                q_m1  <= 1'b0;
                mcand <= {{2{data_operandA[31]}}, data_operandA};
                count <= '0;
            end else if (step) begin
                acc   <= next_acc;
                mreg  <= next_mreg;
                q_m1  <= mreg[1];
                count <= count + 4'd1;
            end
            if (finish) begin
                data_result    <= next_mreg;
                data_exception <= exc_next;
            end
        end
    end

endmodule
